led_pattern_ctrl: RTL

Parametrised LED display controller driven by a small register bank written from the memory-control side.
- Replaces the fixed register-to-LED copy with selectable modes: static, blink, rotate-left and rotate-right.
- Adds a global PWM brightness control.
- Sits between the memory-controller register interface and the board LEDs, all in the clk_25MHz domain.

---
 rtl/led_pattern_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_pattern_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: register map, mode encodings and reset defaults for the LED pattern controller
package led_pattern_pkg;

    localparam logic [1:0] ADDR_MODE    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_DUTY    = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTL   = 2'd2,
        MODE_ROTR   = 2'd3
    } mode_t;

    localparam logic [15:0] PERIOD_RST = 16'd500;
    localparam logic [2:0]  MODE_RST   = 3'd0;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running timebase prescaler plus restartable step counter
module led_tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic        clk_25MHz,
    input  logic        nReset,
    input  logic [15:0] period,
    input  logic        restart,
    output logic        tick,
    output logic        step
);

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic [15:0]   cnt;
    logic [15:0]   last;

    assign last = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign step = tick && !restart && (cnt >= last);

    // prescaler runs continuously and is never restarted by register writes
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) pre <= '0;
        else         pre <= tick ? '0 : pre + 1'b1;
    end

    // step counter counts ticks up to period-1; a restart clears it and swallows any coincident step
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset)      cnt <= '0;
        else if (restart) cnt <= '0;
        else if (tick)    cnt <= (cnt >= last) ? 16'd0 : cnt + 16'd1;
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: register-driven LED controller with static/blink/rotate modes and PWM brightness
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 25000,
    parameter int PWM_BITS = 4
) (
    input  logic             clk_25MHz,
    input  logic             nReset,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [15:0]      wr_data,
    input  logic [1:0]       rd_addr,
    output logic [15:0]      rd_data,
    output logic [N_LED-1:0] LED_out
);

    logic [2:0]          mode_reg;
    logic [N_LED-1:0]    pattern;
    logic [15:0]         period;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LED-1:0]    rot;
    logic [N_LED-1:0]    work;
    logic                phase;
    logic                restart;
    logic                gate;
    logic                step;
    logic                unused_tick;
    logic                unused_bits;
    mode_t               mode;

    assign mode        = mode_t'(mode_reg[1:0]);
    assign restart     = wr_en && (wr_addr != ADDR_DUTY);
    assign unused_bits = ^{wr_data, unused_tick};

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_25MHz (clk_25MHz),
        .nReset    (nReset),
        .period    (period),
        .restart   (restart),
        .tick      (unused_tick),
        .step      (step)
    );

    // register bank writes; upper data bits beyond each field are dropped
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) begin
            mode_reg <= MODE_RST;
            pattern  <= '0;
            period   <= PERIOD_RST;
            duty     <= '1;
        end else if (wr_en) begin
            if (wr_addr == ADDR_MODE)    mode_reg <= wr_data[2:0];
            if (wr_addr == ADDR_PATTERN) pattern  <= wr_data[N_LED-1:0];
            if (wr_addr == ADDR_PERIOD)  period   <= wr_data;
            if (wr_addr == ADDR_DUTY)    duty     <= wr_data[PWM_BITS-1:0];
        end
    end

    // registered readback sees pre-write values on a same-cycle read/write
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) rd_data <= '0;
        else         rd_data <= rd_addr == ADDR_MODE    ? 16'(mode_reg) :
                                rd_addr == ADDR_PATTERN ? 16'(pattern)  :
                                rd_addr == ADDR_PERIOD  ? period        : 16'(duty);
    end

    // animation state: restart reloads from the incoming or current pattern, otherwise advance on step
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) begin
            phase <= 1'b1;
            rot   <= '0;
        end else if (restart) begin
            phase <= 1'b1;
            rot   <= (wr_addr == ADDR_PATTERN) ? wr_data[N_LED-1:0] : pattern;
        end else if (step) begin
            phase <= ~phase;
            rot   <= mode == MODE_ROTL ? {rot[N_LED-2:0], rot[N_LED-1]} :
                     mode == MODE_ROTR ? {rot[0], rot[N_LED-1:1]}       : rot;
        end
    end

    // brightness counter wraps freely every 2^PWM_BITS clocks
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) pwm_cnt <= '0;
        else         pwm_cnt <= pwm_cnt + 1'b1;
    end

    // select the working pattern and brightness gate for the current mode
    always_comb begin
        gate = (duty == '1) || (pwm_cnt < duty);
        work = mode == MODE_STATIC ? pattern :
               mode == MODE_BLINK  ? (phase ? pattern : '0) : rot;
    end

    // output register: disabled forces all LEDs off
    always_ff @(posedge clk_25MHz or negedge nReset) begin
        if (!nReset) LED_out <= '0;
        else         LED_out <= mode_reg[2] ? (work & {N_LED{gate}}) : '0;
    end

endmodule
